// File: rtl/hfg_feature_normalizer_if.sv
// Sample/config bus between the feature accumulator, the normalizer and the
// classifier comparator. The upstream side uses master and the normalizer uses slave.
interface hfg_feature_normalizer_if #(
  parameter int IN_W   = 21,
  parameter int OUT_W  = 32,
  parameter int COEF_W = 16,
  parameter int MODE_W = 2,
  parameter int TAG_W  = 8
);
  logic              iValid;
  logic [IN_W-1:0]   iPre_Feature;
  logic [MODE_W-1:0] iMode;
  logic [TAG_W-1:0]  iTag;
  logic              iStall;
  logic              iCfg_we;
  logic [MODE_W-1:0] iCfg_addr;
  logic [COEF_W-1:0] iCfg_coef;
  logic              oValid;
  logic [OUT_W-1:0]  oFeature;
  logic [TAG_W-1:0]  oTag;
  logic              oSat;

  modport master (
    output iValid, iPre_Feature, iMode, iTag, iStall, iCfg_we, iCfg_addr, iCfg_coef,
    input  oValid, oFeature, oTag, oSat
  );

  modport slave (
    input  iValid, iPre_Feature, iMode, iTag, iStall, iCfg_we, iCfg_addr, iCfg_coef,
    output oValid, oFeature, oTag, oSat
  );
endinterface

// File: rtl/hfg_feature_normalizer.sv
// Three-stage Haar-feature normalizer: sign(x) * ((|x| * COEF[mode]) >> SHIFT),
// with a runtime-loadable coefficient table, stall, tag sideband, rounding and saturation.
module hfg_feature_normalizer #(
  parameter int          IN_W     = 21,
  parameter int          OUT_W    = 32,
  parameter int          COEF_W   = 16,
  parameter int          SHIFT    = 6,
  parameter int          MODE_W   = 2,
  parameter int          TAG_W    = 8,
  parameter int          ROUND    = 0,
  parameter int unsigned COEF_RST = 7959
) (
  input logic                      iClk,
  input logic                      iReset_n,
  hfg_feature_normalizer_if.slave  bus
);
  localparam int          PROD_W = IN_W + COEF_W;
  localparam int          RND_W  = PROD_W + 1;
  localparam int          CMP_W  = (RND_W > OUT_W) ? RND_W : OUT_W;
  localparam int          RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int unsigned DEPTH  = 2 ** MODE_W;
  localparam logic [RND_W-1:0] RND_TERM =
    (ROUND != 0 && SHIFT > 0) ? (RND_W'(1) << RND_SH) : RND_W'(0);
  localparam logic [CMP_W-1:0] MAX_MAG = CMP_W'({(OUT_W-1){1'b1}});

  logic [COEF_W-1:0] coef_tbl [DEPTH];

  logic              s1_valid, s1_sign;
  logic [IN_W-1:0]   s1_mag;
  logic [COEF_W-1:0] s1_coef;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_valid, s2_sign;
  logic [PROD_W-1:0] s2_prod;
  logic [TAG_W-1:0]  s2_tag;

  logic [IN_W-1:0]   in_mag;
  logic [RND_W-1:0]  rnd_sum;
  logic [CMP_W-1:0]  shifted;
  logic              s3_sat;
  logic [OUT_W-1:0]  s3_mag;
  logic [OUT_W-1:0]  s3_feature;

  // Table is read combinationally by S1, so a same-edge write is seen only by later samples.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) coef_tbl[i] <= COEF_W'(COEF_RST);
    end else if (bus.iCfg_we) begin
      coef_tbl[bus.iCfg_addr] <= bus.iCfg_coef;
    end
  end

  // IN_W-bit magnitude holds 2**(IN_W-1) exactly for the most negative input.
  always_comb begin
    in_mag = bus.iPre_Feature[IN_W-1] ? ('0 - bus.iPre_Feature) : bus.iPre_Feature;
  end

  always_comb begin
    rnd_sum    = {1'b0, s2_prod} + RND_TERM;
    shifted    = CMP_W'(rnd_sum >> SHIFT);
    s3_sat     = (shifted > MAX_MAG);
    s3_mag     = s3_sat ? MAX_MAG[OUT_W-1:0] : shifted[OUT_W-1:0];
    s3_feature = s2_sign ? ('0 - s3_mag) : s3_mag;
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      s1_valid     <= 1'b0;
      s1_sign      <= 1'b0;
      s1_mag       <= '0;
      s1_coef      <= '0;
      s1_tag       <= '0;
      s2_valid     <= 1'b0;
      s2_sign      <= 1'b0;
      s2_prod      <= '0;
      s2_tag       <= '0;
      bus.oValid   <= 1'b0;
      bus.oFeature <= '0;
      bus.oTag     <= '0;
      bus.oSat     <= 1'b0;
    end else if (!bus.iStall) begin
      s1_valid     <= bus.iValid;
      s1_sign      <= bus.iPre_Feature[IN_W-1];
      s1_mag       <= in_mag;
      s1_coef      <= coef_tbl[bus.iMode];
      s1_tag       <= bus.iTag;
      s2_valid     <= s1_valid;
      s2_sign      <= s1_sign;
      s2_prod      <= PROD_W'(s1_mag) * PROD_W'(s1_coef);
      s2_tag       <= s1_tag;
      bus.oValid   <= s2_valid;
      bus.oFeature <= s3_feature;
      bus.oTag     <= s2_tag;
      bus.oSat     <= s3_sat;
    end
  end
endmodule

// File: tb/tb_hfg_feature_normalizer.sv
// Directed bench for hfg_feature_normalizer: default, rounding and 24-bit saturating
// instances share one clock and reset.
module tb_hfg_feature_normalizer;
  logic iClk = 1'b0;
  logic iReset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 iClk = ~iClk;

  hfg_feature_normalizer_if #(.OUT_W(32)) bus_def ();
  hfg_feature_normalizer_if #(.OUT_W(32)) bus_rnd ();
  hfg_feature_normalizer_if #(.OUT_W(24)) bus_sat ();

  hfg_feature_normalizer #(.OUT_W(32), .ROUND(0)) u_def (.iClk(iClk), .iReset_n(iReset_n), .bus(bus_def));
  hfg_feature_normalizer #(.OUT_W(32), .ROUND(1)) u_rnd (.iClk(iClk), .iReset_n(iReset_n), .bus(bus_rnd));
  hfg_feature_normalizer #(.OUT_W(24), .ROUND(0)) u_sat (.iClk(iClk), .iReset_n(iReset_n), .bus(bus_sat));

  task automatic step;
    @(posedge iClk);
    #1;
  endtask

  task automatic idle_all;
    bus_def.iValid = 0; bus_def.iPre_Feature = '0; bus_def.iMode = '0; bus_def.iTag = '0;
    bus_def.iStall = 0; bus_def.iCfg_we = 0; bus_def.iCfg_addr = '0; bus_def.iCfg_coef = '0;
    bus_rnd.iValid = 0; bus_rnd.iPre_Feature = '0; bus_rnd.iMode = '0; bus_rnd.iTag = '0;
    bus_rnd.iStall = 0; bus_rnd.iCfg_we = 0; bus_rnd.iCfg_addr = '0; bus_rnd.iCfg_coef = '0;
    bus_sat.iValid = 0; bus_sat.iPre_Feature = '0; bus_sat.iMode = '0; bus_sat.iTag = '0;
    bus_sat.iStall = 0; bus_sat.iCfg_we = 0; bus_sat.iCfg_addr = '0; bus_sat.iCfg_coef = '0;
  endtask

  task automatic test_reset;
    idle_all();
    step();
    // Stall and a config write asserted during reset must both be overridden.
    bus_def.iStall = 1; bus_def.iCfg_we = 1; bus_def.iCfg_addr = 2'd0; bus_def.iCfg_coef = 16'd1;
    iReset_n = 0;
    step();
    iReset_n = 1;
    idle_all();
    checks++; if (bus_def.oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus_def.oValid); end
    checks++; if (bus_def.oFeature !== 32'd0) begin errors++; $display("FAIL reset_feature got=%0h exp=0", bus_def.oFeature); end
    checks++; if (bus_def.oTag !== 8'd0) begin errors++; $display("FAIL reset_tag got=%0h exp=0", bus_def.oTag); end
    checks++; if (bus_def.oSat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%0b exp=0", bus_def.oSat); end
    checks++; if (bus_sat.oValid !== 1'b0) begin errors++; $display("FAIL reset_valid_sat got=%0b exp=0", bus_sat.oValid); end
  endtask

  task automatic test_latency;
    bus_def.iValid = 1; bus_def.iPre_Feature = 21'd1000; bus_def.iMode = 2'd0; bus_def.iTag = 8'h11;
    step();
    bus_def.iValid = 0;
    checks++; if (bus_def.oValid !== 1'b0) begin errors++; $display("FAIL lat_cycle1 got=%0b exp=0", bus_def.oValid); end
    step();
    checks++; if (bus_def.oValid !== 1'b0) begin errors++; $display("FAIL lat_cycle2 got=%0b exp=0", bus_def.oValid); end
    step();
    checks++; if (bus_def.oValid !== 1'b1) begin errors++; $display("FAIL lat_cycle3 got=%0b exp=1", bus_def.oValid); end
    checks++; if (bus_def.oFeature !== 32'd124359) begin errors++; $display("FAIL x1000 got=%0d exp=124359", bus_def.oFeature); end
    checks++; if (bus_def.oTag !== 8'h11) begin errors++; $display("FAIL x1000_tag got=%0h exp=11", bus_def.oTag); end
    checks++; if (bus_def.oSat !== 1'b0) begin errors++; $display("FAIL x1000_sat got=%0b exp=0", bus_def.oSat); end
    step();
    checks++; if (bus_def.oValid !== 1'b0) begin errors++; $display("FAIL lat_bubble got=%0b exp=0", bus_def.oValid); end
  endtask

  task automatic test_negative;
    bus_def.iValid = 1; bus_def.iPre_Feature = 21'(-1000); bus_def.iTag = 8'h21;
    step();
    bus_def.iPre_Feature = 21'h100000; bus_def.iTag = 8'h22;
    step();
    bus_def.iValid = 0;
    step();
    checks++; if (bus_def.oValid !== 1'b1 || bus_def.oFeature !== 32'(-124359) || bus_def.oTag !== 8'h21)
      begin errors++; $display("FAIL neg1000 got=%0d/%0b/%0h exp=-124359/1/21", $signed(bus_def.oFeature), bus_def.oValid, bus_def.oTag); end
    step();
    checks++; if (bus_def.oValid !== 1'b1 || bus_def.oFeature !== 32'(-130400256) || bus_def.oTag !== 8'h22)
      begin errors++; $display("FAIL most_neg got=%0d/%0b/%0h exp=-130400256/1/22", $signed(bus_def.oFeature), bus_def.oValid, bus_def.oTag); end
    step();
  endtask

  task automatic test_round;
    // Entry 2 of the rounding instance gets coef 0 so a negative input yields zero magnitude.
    bus_rnd.iCfg_we = 1; bus_rnd.iCfg_addr = 2'd2; bus_rnd.iCfg_coef = 16'd0;
    step();
    bus_rnd.iCfg_we = 0;
    bus_rnd.iValid = 1; bus_rnd.iPre_Feature = 21'd8; bus_rnd.iMode = 2'd0;
    bus_def.iValid = 1; bus_def.iPre_Feature = 21'd8; bus_def.iMode = 2'd0;
    step();
    bus_def.iValid = 0;
    bus_rnd.iPre_Feature = 21'd0;
    step();
    bus_rnd.iPre_Feature = 21'(-5); bus_rnd.iMode = 2'd2;
    step();
    bus_rnd.iValid = 0;
    checks++; if (bus_rnd.oFeature !== 32'd995) begin errors++; $display("FAIL round_x8 got=%0d exp=995", bus_rnd.oFeature); end
    checks++; if (bus_def.oFeature !== 32'd994) begin errors++; $display("FAIL trunc_x8 got=%0d exp=994", bus_def.oFeature); end
    step();
    checks++; if (bus_rnd.oValid !== 1'b1 || bus_rnd.oFeature !== 32'd0) begin errors++; $display("FAIL round_zero got=%0d exp=0", bus_rnd.oFeature); end
    step();
    checks++; if (bus_rnd.oValid !== 1'b1 || bus_rnd.oFeature !== 32'd0) begin errors++; $display("FAIL neg_zero_mag got=%0d exp=0", bus_rnd.oFeature); end
    step();
  endtask

  task automatic test_saturate;
    bus_sat.iValid = 1; bus_sat.iPre_Feature = 21'd100000; bus_sat.iMode = 2'd0;
    bus_def.iValid = 1; bus_def.iPre_Feature = 21'd100000; bus_def.iMode = 2'd0;
    step();
    bus_def.iValid = 0;
    bus_sat.iPre_Feature = 21'(-100000);
    step();
    bus_sat.iValid = 0;
    step();
    checks++; if (bus_sat.oFeature !== 24'd8388607 || bus_sat.oSat !== 1'b1)
      begin errors++; $display("FAIL sat_pos got=%0d/%0b exp=8388607/1", bus_sat.oFeature, bus_sat.oSat); end
    checks++; if (bus_def.oFeature !== 32'd12435937 || bus_def.oSat !== 1'b0)
      begin errors++; $display("FAIL nosat_32 got=%0d/%0b exp=12435937/0", bus_def.oFeature, bus_def.oSat); end
    step();
    checks++; if (bus_sat.oFeature !== 24'(-8388607) || bus_sat.oSat !== 1'b1)
      begin errors++; $display("FAIL sat_neg got=%0d/%0b exp=-8388607/1", $signed(bus_sat.oFeature), bus_sat.oSat); end
    step();
  endtask

  task automatic test_coef_write;
    bus_def.iCfg_we = 1; bus_def.iCfg_addr = 2'd1; bus_def.iCfg_coef = 16'd4096;
    bus_def.iValid = 1; bus_def.iPre_Feature = 21'd64; bus_def.iMode = 2'd1; bus_def.iTag = 8'h51;
    step();
    bus_def.iCfg_we = 0; bus_def.iTag = 8'h52;
    step();
    bus_def.iValid = 0;
    step();
    checks++; if (bus_def.oFeature !== 32'd7959 || bus_def.oTag !== 8'h51)
      begin errors++; $display("FAIL coef_old got=%0d/%0h exp=7959/51", bus_def.oFeature, bus_def.oTag); end
    step();
    checks++; if (bus_def.oFeature !== 32'd4096 || bus_def.oTag !== 8'h52)
      begin errors++; $display("FAIL coef_new got=%0d/%0h exp=4096/52", bus_def.oFeature, bus_def.oTag); end
    step();
  endtask

  task automatic test_back_to_back;
    int   sent;
    int   got;
    int   extra;
    logic stall_now;
    sent = 0; got = 0; extra = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      stall_now = (c >= 4 && c < 8);
      bus_def.iStall = stall_now;
      bus_def.iValid = (sent < 10);
      bus_def.iPre_Feature = 21'(64 * (sent + 1));
      bus_def.iMode = 2'd0;
      bus_def.iTag = 8'(sent);
      step();
      if (!stall_now && sent < 10) sent++;
      if (!stall_now && bus_def.oValid) begin
        checks++;
        if (bus_def.oTag !== 8'(got) || bus_def.oFeature !== 32'(7959 * (got + 1)))
          begin errors++; $display("FAIL stream_%0d got=%0d/%0h exp=%0d/%0h", got, bus_def.oFeature, bus_def.oTag, 7959 * (got + 1), got); end
        got++;
      end
    end
    bus_def.iValid = 0; bus_def.iStall = 0;
    checks++; if (got !== 10) begin errors++; $display("FAIL stream_count got=%0d exp=10", got); end
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus_def.oValid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL stream_dup got=%0d exp=0", extra); end

    // Samples in flight when reset hits must vanish, not drain out afterwards.
    bus_def.iValid = 1; bus_def.iPre_Feature = 21'd64; bus_def.iTag = 8'hA0;
    step();
    bus_def.iTag = 8'hA1;
    step();
    bus_def.iStall = 1; bus_def.iValid = 0;
    iReset_n = 0;
    step();
    iReset_n = 1; bus_def.iStall = 0;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus_def.oValid) extra++;
      step();
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL post_reset_valid got=%0d exp=0", extra); end
    bus_def.iValid = 1; bus_def.iPre_Feature = 21'd64; bus_def.iMode = 2'd1; bus_def.iTag = 8'hB0;
    step();
    bus_def.iValid = 0;
    step();
    step();
    checks++; if (bus_def.oValid !== 1'b1 || bus_def.oFeature !== 32'd7959)
      begin errors++; $display("FAIL post_reset_coef got=%0d/%0b exp=7959/1", bus_def.oFeature, bus_def.oValid); end
    step();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_negative();
    test_round();
    test_saturate();
    test_coef_write();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
